// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared constants, FSM state type and index helper for the event encoder
package encoder_pkg;

  localparam int N  = 8;
  localparam int CW = 3;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  function automatic logic [N-1:0] idx2mask(input logic [CW-1:0] idx);
    return N'(1) << idx;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// rtl/prio_enc8.sv - combinational 8-to-3 priority encoder, highest set bit wins
module prio_enc8
  import encoder_pkg::*;
(
  input  logic [N-1:0]  i_vec,
  output logic [CW-1:0] o_idx,
  output logic          o_any
);

  // Ascending scan: the last (highest) set bit overwrites earlier matches.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) begin
        o_idx = CW'(i);
      end
    end
  end

  assign o_any = |i_vec;

endmodule

// File: rtl/encoder_8_3_evt.sv
// rtl/encoder_8_3_evt.sv - edge-captured 8-line event encoder emitting indices over valid/ready
module encoder_8_3_evt
  import encoder_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [CW-1:0] code,
  output logic          valid,
  input  logic          ready,
  output logic [N-1:0]  pending,
  output logic          overflow
);

  logic [N-1:0]  r_req_q;
  logic [N-1:0]  r_pending;
  logic [CW-1:0] r_code;
  logic          r_valid;
  logic          r_overflow;
  state_t        r_state;

  state_t        w_state_nxt;
  logic          w_launch;
  logic [N-1:0]  w_edge;
  logic [N-1:0]  w_cap;
  logic [N-1:0]  w_clr;
  logic [N-1:0]  w_pend_nxt;
  logic          w_ovf;
  logic [CW-1:0] w_sel;
  logic          w_any;

  assign w_edge = req & ~r_req_q;

  prio_enc8 u_prio (
    .i_vec (r_pending),
    .o_idx (w_sel),
    .o_any (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      IDLE: begin
        if (en && w_any) begin
          w_launch    = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (ready) begin
          if (en && w_any) begin
            w_launch = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture is OR-ed in after the launch clear, so a same-bit edge keeps the bit pending.
  always_comb begin
    w_clr      = w_launch ? idx2mask(w_sel) : '0;
    w_cap      = en ? w_edge : '0;
    w_pend_nxt = (r_pending & ~w_clr) | w_cap;
    w_ovf      = |(w_cap & r_pending & ~w_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_q    <= '0;
      r_pending  <= '0;
      r_code     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_req_q    <= req;
      r_pending  <= w_pend_nxt;
      r_overflow <= w_ovf;
      r_valid    <= (w_state_nxt == SEND);
      if (w_launch) begin
        r_code <= w_sel;
      end
    end
  end

  assign code     = r_code;
  assign valid    = r_valid;
  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_encoder_8_3_evt.sv
// tb/tb_encoder_8_3_evt.sv - scoreboard bench for encoder_8_3_evt
module tb_encoder_8_3_evt;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [2:0] code;
  logic       valid;
  logic       ready;
  logic [7:0] pending;
  logic       overflow;

  int n_tests;
  int n_fail;
  int xfer_cnt;
  int ovf_cnt;
  logic [2:0] sb[$];

  encoder_8_3_evt dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .code     (code),
    .valid    (valid),
    .ready    (ready),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake happens at the next rising edge; inputs are stable since posedge+1.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      logic [2:0] exp_code;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL xfer_unexpected: got code=%0d, required no transfer", code);
      end else begin
        exp_code = sb.pop_front();
        if (code !== exp_code) begin
          n_fail++;
          $display("FAIL xfer_code: got %0d, required %0d", code, exp_code);
        end
      end
      xfer_cnt++;
    end
    if (rst_n && overflow === 1'b1) ovf_cnt++;
  end

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; req = '0; ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", valid); end
    n_tests++;
    if (code !== 3'd0) begin n_fail++; $display("FAIL reset_code: got %0d, required 0", code); end
    n_tests++;
    if (pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending: got %h, required 00", pending); end
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    en = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    req = 8'h20; sb.push_back(3'd5);
    @(posedge clk); #1;
    req = 8'h00;
    @(negedge clk);
    n_tests++;
    if (pending !== 8'h20 || valid !== 1'b0) begin
      n_fail++; $display("FAIL single_capture: got pending=%h valid=%b, required 20/0", pending, valid);
    end
    @(negedge clk);
    n_tests++;
    if (valid !== 1'b1 || code !== 3'd5 || pending !== 8'h00) begin
      n_fail++; $display("FAIL single_launch: got valid=%b code=%0d pending=%h, required 1/5/00", valid, code, pending);
    end
    @(negedge clk);
    n_tests++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL single_width: got valid=%b, required 0", valid); end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL single_drain: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    en = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    req = 8'b0100_1010;
    sb.push_back(3'd6); sb.push_back(3'd3); sb.push_back(3'd1);
    @(posedge clk); #1;
    req = 8'h00;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b, required 1", k, valid); end
    end
    @(negedge clk);
    n_tests++;
    if (valid !== 1'b0 || pending !== 8'h00) begin
      n_fail++; $display("FAIL b2b_end: got valid=%b pending=%h, required 0/00", valid, pending);
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_hold();
    int x0;
    en = 1'b1; ready = 1'b0;
    @(posedge clk); #1;
    req = 8'h04; sb.push_back(3'd2);
    @(posedge clk); #1;
    req = 8'h00;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_tests++;
      if (valid !== 1'b1 || code !== 3'd2) begin
        n_fail++; $display("FAIL hold[%0d]: got valid=%b code=%0d, required 1/2", k, valid, code);
      end
    end
    x0 = xfer_cnt;
    @(posedge clk); #1;
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (valid !== 1'b0 || xfer_cnt - x0 != 1) begin
      n_fail++; $display("FAIL hold_release: got valid=%b xfers=%0d, required 0/1", valid, xfer_cnt - x0);
    end
  endtask

  task automatic test_overflow();
    int o0, x0;
    o0 = ovf_cnt; x0 = xfer_cnt;
    en = 1'b1; ready = 1'b0;
    @(posedge clk); #1;
    req = 8'h04; sb.push_back(3'd2); sb.push_back(3'd4);
    @(posedge clk); #1; req = 8'h00;
    @(posedge clk); #1; req = 8'h10;
    @(posedge clk); #1; req = 8'h00;
    @(posedge clk); #1; req = 8'h10;
    @(posedge clk); #1; req = 8'h00;
    repeat (3) @(negedge clk);
    n_tests++;
    if (ovf_cnt - o0 != 1) begin n_fail++; $display("FAIL ovf_pulses: got %0d, required 1", ovf_cnt - o0); end
    n_tests++;
    if (pending !== 8'h10 || valid !== 1'b1 || code !== 3'd2) begin
      n_fail++; $display("FAIL ovf_state: got pending=%h valid=%b code=%0d, required 10/1/2", pending, valid, code);
    end
    @(posedge clk); #1;
    ready = 1'b1;
    repeat (4) @(posedge clk);
    #1; ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (xfer_cnt - x0 != 2 || sb.size() != 0) begin
      n_fail++; $display("FAIL ovf_xfers: got %0d xfers %0d left, required 2/0", xfer_cnt - x0, sb.size());
    end
  endtask

  task automatic test_enable();
    en = 1'b0; ready = 1'b1;
    @(posedge clk); #1;
    req = 8'h80;
    repeat (4) @(negedge clk);
    n_tests++;
    if (valid !== 1'b0 || pending !== 8'h00) begin
      n_fail++; $display("FAIL en_off: got valid=%b pending=%h, required 0/00", valid, pending);
    end
    @(posedge clk); #1;
    en = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if (valid !== 1'b0 || pending !== 8'h00) begin
      n_fail++; $display("FAIL en_level: got valid=%b pending=%h, required 0/00", valid, pending);
    end
    @(posedge clk); #1;
    req = 8'h00;
  endtask

  task automatic test_reset_mid();
    int x0;
    en = 1'b1; ready = 1'b0;
    @(posedge clk); #1; req = 8'h80;
    @(posedge clk); #1; req = 8'h00;
    @(posedge clk); #1; req = 8'hA0;
    @(posedge clk); #1; req = 8'h00;
    @(negedge clk);
    n_tests++;
    if (valid !== 1'b1 || code !== 3'd7 || pending !== 8'hA0) begin
      n_fail++; $display("FAIL rstmid_pre: got valid=%b code=%0d pending=%h, required 1/7/a0", valid, code, pending);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (valid !== 1'b0 || code !== 3'd0 || pending !== 8'h00 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async: got valid=%b code=%0d pending=%h ovf=%b, required all 0", valid, code, pending, overflow);
    end
    ready = 1'b1;
    x0 = xfer_cnt;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_tests++;
    if (xfer_cnt != x0 || valid !== 1'b0 || pending !== 8'h00) begin
      n_fail++; $display("FAIL rstmid_after: got xfers=%0d valid=%b pending=%h, required 0/0/00", xfer_cnt - x0, valid, pending);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; xfer_cnt = 0; ovf_cnt = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_overflow();
    test_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

endmodule

// File: doc/encoder_8_3_evt.md
# encoder_8_3_evt

Sequential 8-to-3 event encoder: the return path for the 3-to-8 decoder. It captures rising edges on eight request lines into a pending set. It emits each event as a 3-bit index over a valid/ready handshake, highest index first. It sits between raw event sources (one-hot strobes from decoded peripherals) and a narrow consumer that takes one index per transfer.

## Interface
Parameters:
- N, 8, number of request lines (fixed at 8 in this revision)
- CW, 3, code width, clog2(N)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  enable; when 0, no capture and no new launch
- req  in  8  level request lines, edge-detected internally
- code  out  3  index of emitted event
- valid  out  1  code holds an unaccepted event
- ready  in  1  consumer accepts when valid & ready at a rising clk
- pending  out  8  registered set of captured, not-yet-emitted events
- overflow  out  1  one-cycle pulse: a captured edge hit a bit already pending

## Operation
- Edge detect: req_q <= req every cycle regardless of en; edge = req & ~req_q.
- Capture (en=1): pending[i] set on edge[i]. With en=0, edges are dropped, and req_q still updates.
- overflow = 1 for one cycle when en & edge[i] & pending[i] for any i after the launch clear. The event is merged and not counted twice.
- Priority: bit 7 highest. The selected index is the highest set bit of pending.
- FSM states:
  - IDLE: valid=0. If en & pending!=0, load code=prio(pending), clear that bit, valid<=1, go SEND.
  - SEND: valid=1, code stable. On ready:
    - if en & (pending after this cycle's clear) != 0, load the next index back-to-back and stay in SEND;
    - else valid<=0 and go IDLE.
  - Without ready, hold code/valid.
- en=0 while in SEND: the held event stays valid until accepted, then go IDLE. No launch happens while en=0.
- Simultaneous clear and edge on the same bit in one cycle: set wins. The bit stays pending and overflow does not fire.
- Edges arriving in a launch cycle become visible to selection from the next cycle. They are never lost.

## Timing
- Reset values: code=0, valid=0, pending=0, overflow=0, req_q=0, state=IDLE.
  - A req held high through reset release produces an edge on the first clock.
- Latency, capture path: req rises before edge t → pending set after t. From IDLE, valid and code are set after t+1, so 2 cycles.
- Throughput: one event per clock while ready=1 and pending is non-empty.
- valid and code change only at rising clk. code is stable while valid & ~ready.
- Reset asserted mid-transfer: all state clears immediately (asynchronous). In-flight and pending events are discarded.
- All outputs are registered. There are no combinational paths from ready or req to any output.

## Structure
- Package encoder_pkg holds:
  - constants N=8, CW=3;
  - the enum state_t {IDLE, SEND}.
- Sub-module prio_enc8: combinational. Input 8-bit vector; outputs 3-bit index of the highest set bit and an any flag. It is the inverse of the existing decoder, and is reusable.
- Top module holds the edge register, pending register, FSM and output registers.

## Test plan
- Reset, then a req[5] pulse with en=1, ready=1 → code=5, valid=1 two cycles after the edge, one cycle wide; pending returns to 0.
- req[1], req[6], req[3] rise in the same cycle with ready=1 → codes 6, 3, 1 on three consecutive cycles, valid continuous.
- ready=0 with req[2] captured → valid=1 and code=2 held for 10 cycles. Raising ready gives exactly one transfer.
- req[4] pulses twice while still pending (ready=0) → overflow pulses once, and only one code=4 transfer occurs.
- en=0 while req[7] rises → no capture and valid stays 0. Setting en=1 later with req still high → still no event, since no new edge.
- rst_n dropped while valid=1 and pending=8'b1010_0000 → all outputs 0 immediately, with no transfers after release.
